// File: rtl/fhe_intc_route_cfg_pkg.sv
// Purpose: shared types and constants for the Benes interconnect route configurator.
//  Holds command codes, the command port payload, the route register bundle,
//  error bit positions and the configurator FSM state type.
package fhe_intc_route_cfg_pkg;

  localparam int unsigned STAGE_NUM         = 9;
  localparam int unsigned RING_ROUTER_DELAY = 2;

  localparam int unsigned NUM_STAGES    = STAGE_NUM;
  localparam int unsigned SEL_W         = 16;
  localparam int unsigned SETTLE_CYCLES = RING_ROUTER_DELAY;
  localparam int unsigned DRAIN_TIMEOUT = 255;

  localparam int unsigned CMD_W        = 8;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ERR_W        = 3;
  localparam int unsigned STAGE_IDX_W  = $clog2(NUM_STAGES);
  localparam int unsigned DRAIN_CNT_W  = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned SETTLE_CNT_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CMD_W-1:0] COMMAND_SET_MODULE1 = 8'd20;
  localparam logic [CMD_W-1:0] COMMAND_SET_RAM1    = 8'd23;
  localparam logic [CMD_W-1:0] COMMAND_SET_RING    = 8'd29;
  localparam logic [CMD_W-1:0] COMMAND_RESET       = 8'd111;

  localparam int unsigned ROUTE_ERR_BAD_STAGE = 0;
  localparam int unsigned ROUTE_ERR_TIMEOUT   = 1;
  localparam int unsigned ROUTE_ERR_UNKNOWN   = 2;

  typedef struct packed {
    logic              valid;
    logic [CMD_W-1:0]  command;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
  } CommandDataPort;

  typedef logic [NUM_STAGES-1:0][SEL_W-1:0] sel_vec_t;

  typedef struct packed {
    sel_vec_t mod;
    sel_vec_t slot;
  } RouteCfgT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DRAIN,
    ST_SETTLE,
    ST_DONE
  } route_state_t;

endpackage

// File: rtl/fhe_intc_route_cfg_bank.sv
// Purpose: shadow + active select register file for the Benes interconnect.
//  Ports: clk/rst, wr_mod/wr_slot write enables with wr_idx/wr_data,
//  clear (zero shadow and active), commit (active <= shadow), active (registered).
module fhe_intc_route_cfg_bank
  import fhe_intc_route_cfg_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_mod,
  input  logic                   wr_slot,
  input  logic [STAGE_IDX_W-1:0] wr_idx,
  input  logic [SEL_W-1:0]       wr_data,
  input  logic                   clear,
  input  logic                   commit,
  output RouteCfgT               active
);

  RouteCfgT shadow;

  // Stage writes land in the shadow; only a commit moves them to the active copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else if (clear) begin
      shadow <= '0;
      active <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (wr_mod && (wr_idx == STAGE_IDX_W'(i))) shadow.mod[i] <= wr_data;
        if (wr_slot && (wr_idx == STAGE_IDX_W'(i))) shadow.slot[i] <= wr_data;
      end
      if (commit) active <= shadow;
    end
  end

endmodule

// File: rtl/fhe_intc_route_cfg.sv
// Purpose: consumes command stream, stages Benes select words and commits them
//  atomically after the interconnect drains, stalling ALU issue while it settles.
//  Ports: clk, rst (async high), i_cmd (command port), o_cmd_ready,
//  i_intc_idle, o_module_select / o_slot_select (active selects), o_stall,
//  o_commit_done (1-cycle pulse), o_err (sticky: bad stage, drain timeout, unknown cmd).
module fhe_intc_route_cfg
  import fhe_intc_route_cfg_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  CommandDataPort                      i_cmd,
  output logic                                o_cmd_ready,
  input  logic                                i_intc_idle,
  output logic [NUM_STAGES-1:0][SEL_W-1:0]    o_module_select,
  output logic [NUM_STAGES-1:0][SEL_W-1:0]    o_slot_select,
  output logic                                o_stall,
  output logic                                o_commit_done,
  output logic [ERR_W-1:0]                    o_err
);

  route_state_t            state;
  logic [DRAIN_CNT_W-1:0]  drain_cnt;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  RouteCfgT                active;

  logic cmd_fire_c;
  logic bad_stage_c;
  logic wr_mod_c;
  logic wr_slot_c;
  logic clear_c;
  logic commit_c;
  logic unused_c;

  // Bank control decoded straight from the accepted command / drain condition.
  assign cmd_fire_c  = i_cmd.valid && (state == ST_IDLE);
  assign bad_stage_c = i_cmd.data0 >= DATA_W'(NUM_STAGES);
  assign wr_mod_c    = cmd_fire_c && (i_cmd.command == COMMAND_SET_MODULE1) && !bad_stage_c;
  assign wr_slot_c   = cmd_fire_c && (i_cmd.command == COMMAND_SET_RAM1) && !bad_stage_c;
  assign clear_c     = cmd_fire_c && (i_cmd.command == COMMAND_RESET);
  assign commit_c    = (state == ST_WAIT_DRAIN) && i_intc_idle;
  assign unused_c    = ^i_cmd.data1[DATA_W-1:SEL_W];

  fhe_intc_route_cfg_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_mod  (wr_mod_c),
    .wr_slot (wr_slot_c),
    .wr_idx  (i_cmd.data0[STAGE_IDX_W-1:0]),
    .wr_data (i_cmd.data1[SEL_W-1:0]),
    .clear   (clear_c),
    .commit  (commit_c),
    .active  (active)
  );

  assign o_module_select = active.mod;
  assign o_slot_select   = active.slot;

  // Commit sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      drain_cnt     <= '0;
      settle_cnt    <= '0;
      o_cmd_ready   <= 1'b1;
      o_stall       <= 1'b0;
      o_commit_done <= 1'b0;
      o_err         <= '0;
    end else begin
      o_commit_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_fire_c) begin
            case (i_cmd.command)
              COMMAND_SET_MODULE1,
              COMMAND_SET_RAM1: begin
                if (bad_stage_c) o_err[ROUTE_ERR_BAD_STAGE] <= 1'b1;
              end
              COMMAND_SET_RING: begin
                state       <= ST_WAIT_DRAIN;
                drain_cnt   <= '0;
                o_cmd_ready <= 1'b0;
                o_stall     <= 1'b1;
              end
              COMMAND_RESET: o_err <= '0;
              default:       o_err[ROUTE_ERR_UNKNOWN] <= 1'b1;
            endcase
          end
        end
        ST_WAIT_DRAIN: begin
          if (drain_cnt != '1) drain_cnt <= drain_cnt + DRAIN_CNT_W'(1);
          // Idle takes priority over a timeout landing in the same cycle.
          if (i_intc_idle) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end else if (drain_cnt >= DRAIN_CNT_W'(DRAIN_TIMEOUT - 1)) begin
            state                     <= ST_IDLE;
            o_err[ROUTE_ERR_TIMEOUT]  <= 1'b1;
            o_stall                   <= 1'b0;
            o_cmd_ready               <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt >= SETTLE_CNT_W'(SETTLE_CYCLES - 1)) begin
            state         <= ST_DONE;
            o_stall       <= 1'b0;
            o_commit_done <= 1'b1;
          end else if (settle_cnt != '1) begin
            settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          o_cmd_ready <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          o_cmd_ready <= 1'b1;
          o_stall     <= 1'b0;
        end
      endcase
    end
  end

endmodule
